// File: rtl/axis_multiword_addsub.sv
// Sequential multi-word add/subtract over AXI-Stream: one WORD_WIDTH slice per beat,
// LS slice first, with the carry/borrow chained between beats in a register.
module axis_multiword_addsub #(
  parameter int    WORD_WIDTH   = 16,
  parameter string ADD_MODE     = "ADD/SUBTRACT",
  parameter string OP_TYPE      = "SIGNED",
  parameter string BORROW_SENSE = "ACTIVE_LOW"
) (
  input  logic                    CLK,
  input  logic                    ARESETN,
  input  logic [2*WORD_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    C_IN,
  output logic [WORD_WIDTH-1:0]   m_axis_tdata,
  output logic [1:0]              m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam bit FIXED_ADD   = (ADD_MODE == "ADD");
  localparam bit FIXED_SUB   = (ADD_MODE == "SUBTRACT");
  localparam bit MODE_OK     = FIXED_ADD || FIXED_SUB || (ADD_MODE == "ADD/SUBTRACT");
  localparam bit IS_SIGNED   = (OP_TYPE == "SIGNED");
  localparam bit BORROW_HIGH = (BORROW_SENSE == "ACTIVE_HIGH");

  generate
    if (WORD_WIDTH < 1 || !MODE_OK) begin : g_bad_param
      $fatal(1, "axis_multiword_addsub: bad WORD_WIDTH or ADD_MODE");
    end
  endgenerate

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic [1:0]            user;
    logic                  last;
  } beat_t;

  beat_t out_q, out_d;
  logic  m_tvalid_q, m_tvalid_d;
  logic  first_q, first_d;
  logic  op_add_q, op_add_d;
  logic  carry_q, carry_d;

  logic                  accept, op_add, sub, cin, co, c_msb, c_out, ovf;
  logic [WORD_WIDTH-1:0] a, b, bx, sum;

  assign s_axis_tready = !m_tvalid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    op_add = FIXED_ADD ? 1'b1 : FIXED_SUB ? 1'b0 : (first_q ? s_axis_tuser : op_add_q);
    sub    = !op_add;
    a      = s_axis_tdata[WORD_WIDTH-1:0];
    b      = s_axis_tdata[2*WORD_WIDTH-1:WORD_WIDTH];
    bx     = sub ? ~b : b;
    // Active-high borrow inverts into the adder's native carry sense on the first slice.
    cin    = first_q ? ((sub && BORROW_HIGH) ? !C_IN : C_IN) : carry_q;
    {co, sum} = {1'b0, a} + {1'b0, bx} + {{WORD_WIDTH{1'b0}}, cin};
    c_msb  = a[WORD_WIDTH-1] ^ bx[WORD_WIDTH-1] ^ sum[WORD_WIDTH-1];
    c_out  = (sub && BORROW_HIGH) ? !co : co;
    ovf    = IS_SIGNED ? (c_msb ^ co) : (sub ? !co : co);
  end

  always_comb begin
    first_d    = first_q;
    op_add_d   = op_add_q;
    carry_d    = carry_q;
    m_tvalid_d = m_tvalid_q;
    out_d      = out_q;
    if (accept) begin
      first_d  = s_axis_tlast;
      op_add_d = op_add;
      carry_d  = co;
    end
    if (s_axis_tready) begin
      m_tvalid_d = s_axis_tvalid;
      if (s_axis_tvalid) begin
        out_d.data = sum;
        out_d.user = s_axis_tlast ? {ovf, c_out} : 2'b00;
        out_d.last = s_axis_tlast;
      end
    end
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      first_q    <= 1'b1;
      op_add_q   <= 1'b1;
      carry_q    <= 1'b0;
      m_tvalid_q <= 1'b0;
      out_q      <= '0;
    end else begin
      first_q    <= first_d;
      op_add_q   <= op_add_d;
      carry_q    <= carry_d;
      m_tvalid_q <= m_tvalid_d;
      out_q      <= out_d;
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tuser  = out_q.user;
  assign m_axis_tlast  = out_q.last;

endmodule

// File: tb/tb_axis_multiword_addsub.sv
// Bench: two 8-bit DUTs (signed/active-low and unsigned/active-high borrow) share one stream;
// expected results come from whole-packet integer arithmetic.
module tb_axis_multiword_addsub;

  logic        CLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tuser = 1'b0, s_tlast = 1'b0, s_tvalid = 1'b0, C_IN = 1'b0;
  logic        m_tready = 1'b1;

  logic [7:0]  ms_data, mu_data;
  logic [1:0]  ms_user, mu_user;
  logic        ms_last, mu_last, ms_valid, mu_valid, s_ready_s, s_ready_u;

  int total = 0;
  int bad   = 0;

  logic [7:0] pa[4];
  logic [7:0] pb[4];

  always #5 CLK = ~CLK;

  axis_multiword_addsub #(.WORD_WIDTH(8), .ADD_MODE("ADD/SUBTRACT"), .OP_TYPE("SIGNED"),
    .BORROW_SENSE("ACTIVE_LOW")) dut_s (
    .CLK(CLK), .ARESETN(ARESETN), .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_ready_s), .C_IN(C_IN),
    .m_axis_tdata(ms_data), .m_axis_tuser(ms_user), .m_axis_tlast(ms_last),
    .m_axis_tvalid(ms_valid), .m_axis_tready(m_tready));

  axis_multiword_addsub #(.WORD_WIDTH(8), .ADD_MODE("ADD/SUBTRACT"), .OP_TYPE("UNSIGNED"),
    .BORROW_SENSE("ACTIVE_HIGH")) dut_u (
    .CLK(CLK), .ARESETN(ARESETN), .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_ready_u), .C_IN(C_IN),
    .m_axis_tdata(mu_data), .m_axis_tuser(mu_user), .m_axis_tlast(mu_last),
    .m_axis_tvalid(mu_valid), .m_axis_tready(m_tready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-packet reference: plain integer add/subtract over n*8 bits.
  function automatic void model(input longint A, input longint B, input int n, input bit op_add,
                                input bit cin, input bit ah, input bit sgn,
                                output longint R, output bit cout, output bit ovf);
    longint m, sa, sb, tot, st, br;
    m  = longint'(1) << (8 * n);
    sa = (A >= m / 2) ? A - m : A;
    sb = (B >= m / 2) ? B - m : B;
    if (op_add) begin
      tot  = A + B + longint'(cin);
      st   = sa + sb + longint'(cin);
      R    = tot % m;
      cout = (tot >= m);
      ovf  = sgn ? (st > m / 2 - 1 || st < -(m / 2)) : cout;
    end else begin
      br   = ah ? longint'(cin) : longint'(!cin);
      tot  = A - B - br;
      st   = sa - sb - br;
      R    = (tot + m) % m;
      cout = ah ? (tot < 0) : (tot >= 0);
      ovf  = sgn ? (st > m / 2 - 1 || st < -(m / 2)) : (tot < 0);
    end
  endfunction

  task automatic check_beat(input string tag, input int i, input int n,
                            input longint rs, input bit cs, input bit os,
                            input longint ru, input bit cu, input bit ou);
    logic lst;
    lst = (i == n - 1);
    chk({tag, "_s_vld"},  32'(ms_valid), 32'd1);
    chk({tag, "_s_data"}, 32'(ms_data), 32'((rs >> (8 * i)) & 255));
    chk({tag, "_s_last"}, 32'(ms_last), 32'(lst));
    chk({tag, "_s_user"}, 32'(ms_user), lst ? 32'({os, cs}) : 32'd0);
    chk({tag, "_u_vld"},  32'(mu_valid), 32'd1);
    chk({tag, "_u_data"}, 32'(mu_data), 32'((ru >> (8 * i)) & 255));
    chk({tag, "_u_last"}, 32'(mu_last), 32'(lst));
    chk({tag, "_u_user"}, 32'(mu_user), lst ? 32'({ou, cu}) : 32'd0);
  endtask

  task automatic run_pkt(input string tag, input int n, input bit op_add, input bit cin,
                         input int stall_at, input bit gap);
    longint A = 0, B = 0, rs, ru;
    bit cs, os, cu, ou;
    for (int i = 0; i < n; i++) begin
      A = A | (longint'(pa[i]) << (8 * i));
      B = B | (longint'(pb[i]) << (8 * i));
    end
    model(A, B, n, op_add, cin, 1'b0, 1'b1, rs, cs, os);
    model(A, B, n, op_add, cin, 1'b1, 1'b0, ru, cu, ou);
    m_tready = 1'b1;
    for (int i = 0; i < n; i++) begin
      s_tdata  = {pb[i], pa[i]};
      s_tlast  = (i == n - 1);
      s_tvalid = 1'b1;
      // Later beats carry the opposite op and a random C_IN; both must be ignored.
      s_tuser  = (i == 0) ? op_add : !op_add;
      C_IN     = (i == 0) ? cin : 1'($urandom);
      if (i == stall_at && i > 0) begin
        m_tready = 1'b0;
        repeat (3) begin
          #1;
          chk({tag, "_stall_rdy_s"}, 32'(s_ready_s), 32'd0);
          chk({tag, "_stall_rdy_u"}, 32'(s_ready_u), 32'd0);
          @(posedge CLK); #1;
          check_beat({tag, "_held"}, i - 1, n, rs, cs, os, ru, cu, ou);
        end
        m_tready = 1'b1;
      end
      #1;
      chk({tag, "_rdy"}, 32'({s_ready_s, s_ready_u}), 32'd3);
      @(posedge CLK); #1;
      check_beat(tag, i, n, rs, cs, os, ru, cu, ou);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (gap) begin
      @(posedge CLK); #1;
      chk({tag, "_idle_vld"}, 32'({ms_valid, mu_valid}), 32'd0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"},  32'({ms_valid, mu_valid}), 32'd0);
    chk({tag, "_data"}, 32'({ms_data, mu_data}), 32'd0);
    chk({tag, "_last"}, 32'({ms_last, mu_last}), 32'd0);
    chk({tag, "_user"}, 32'({ms_user, mu_user}), 32'd0);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(negedge CLK) ARESETN = 1'b1;
    @(posedge CLK); #1;

    // Two-beat add with carry across slices: 0x01FF + 0x0001.
    pa[0] = 8'hFF; pb[0] = 8'h01; pa[1] = 8'h01; pb[1] = 8'h00;
    run_pkt("add2", 2, 1'b1, 1'b0, -1, 1'b1);

    // 0x0100 - 0x0001 with borrow chain.
    pa[0] = 8'h00; pb[0] = 8'h01; pa[1] = 8'h01; pb[1] = 8'h00;
    run_pkt("sub2", 2, 1'b0, 1'b1, -1, 1'b1);

    pa[0] = 8'h7F; pb[0] = 8'h01;
    run_pkt("ovf7f", 1, 1'b1, 1'b0, -1, 1'b1);
    pa[0] = 8'hFF; pb[0] = 8'h01;
    run_pkt("ffp1", 1, 1'b1, 1'b0, -1, 1'b1);

    // Same 3-beat packet unstalled, then stalled mid-packet.
    pa[0] = 8'hF0; pb[0] = 8'h35; pa[1] = 8'hFF; pb[1] = 8'h00; pa[2] = 8'h12; pb[2] = 8'h34;
    run_pkt("nostall", 3, 1'b1, 1'b1, -1, 1'b1);
    run_pkt("stall", 3, 1'b1, 1'b1, 1, 1'b1);
    run_pkt("stallsub", 3, 1'b0, 1'b0, 2, 1'b1);

    // Back-to-back single-beat packets: no carry leak.
    pa[0] = 8'hFF; pb[0] = 8'h01;
    run_pkt("b2b_a", 1, 1'b1, 1'b0, -1, 1'b0);
    pa[0] = 8'h00; pb[0] = 8'h00;
    run_pkt("b2b_b", 1, 1'b1, 1'b0, -1, 1'b1);

    // Reset after the first beat of a 3-beat packet.
    s_tdata = 16'h01FF; s_tlast = 1'b0; s_tvalid = 1'b1; s_tuser = 1'b1; C_IN = 1'b0;
    @(posedge CLK); #1;
    chk("rst_pre_vld", 32'({ms_valid, mu_valid}), 32'd3);
    ARESETN = 1'b0;
    #1;
    chk_zero("rst_mid");
    s_tvalid = 1'b0;
    @(negedge CLK) ARESETN = 1'b1;
    @(posedge CLK); #1;
    pa[0] = 8'h05; pb[0] = 8'h03;
    run_pkt("post_rst", 1, 1'b1, 1'b0, -1, 1'b1);
    chk("post_rst_const", 32'((longint'(pa[0]) + longint'(pb[0])) & 255), 32'h08);

    for (int k = 0; k < 40; k++) begin
      int n, st;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) begin
        pa[i] = 8'($urandom);
        pb[i] = 8'($urandom);
      end
      st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : -1;
      run_pkt("rnd", n, 1'($urandom), 1'($urandom), st, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
